// File: rtl/ofm_collector.sv
// Collects per-lane PE output bytes into a 16-byte group and streams it as four 32-bit words.
// Optional macro OFM_COLLECTOR_RELU_EN clamps negative (bit7=1) bytes to zero on capture.
module ofm_collector #(
  parameter logic [15:0] LANE_MASK = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  OFM_0,
  input  logic [7:0]  OFM_1,
  input  logic [7:0]  OFM_2,
  input  logic [7:0]  OFM_3,
  input  logic [7:0]  OFM_4,
  input  logic [7:0]  OFM_5,
  input  logic [7:0]  OFM_6,
  input  logic [7:0]  OFM_7,
  input  logic [7:0]  OFM_8,
  input  logic [7:0]  OFM_9,
  input  logic [7:0]  OFM_10,
  input  logic [7:0]  OFM_11,
  input  logic [7:0]  OFM_12,
  input  logic [7:0]  OFM_13,
  input  logic [7:0]  OFM_14,
  input  logic [7:0]  OFM_15,
  input  logic [15:0] valid,
  input  logic        flush,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        overflow
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state_q;
  logic [1:0]        cnt_q;
  logic [15:0]       flag_q, flag_d;
  logic [15:0][7:0]  cap_q, cap_d;
  logic [15:0][7:0]  snd_q, snd_d;
  logic              ovf_q, ovf_d;
  logic [15:0][7:0]  ofm_w;
  logic [15:0]       flag_base;
  logic              grp_complete;
  logic              xfer;

  assign ofm_w = {OFM_15, OFM_14, OFM_13, OFM_12, OFM_11, OFM_10, OFM_9, OFM_8,
                  OFM_7,  OFM_6,  OFM_5,  OFM_4,  OFM_3,  OFM_2,  OFM_1, OFM_0};

  function automatic logic [7:0] relu_byte(input logic [7:0] b);
`ifdef OFM_COLLECTOR_RELU_EN
    return b[7] ? 8'h00 : b;
`else
    return b;
`endif
  endfunction

  assign grp_complete = ((flag_q & LANE_MASK) == LANE_MASK);
  // An empty flush is not a transfer; a flush in SEND is simply not looked at.
  assign xfer         = (state_q == IDLE) && (grp_complete || (flush && (|flag_q)));
  assign flag_base    = xfer ? 16'h0000 : flag_q;

  always_comb begin
    cap_d  = cap_q;
    flag_d = flag_base;
    ovf_d  = ovf_q;
    snd_d  = snd_q;
    for (int i = 0; i < 16; i++) begin
      if (valid[i]) begin
        if (!flag_base[i]) begin
          cap_d[i]  = relu_byte(ofm_w[i]);
          flag_d[i] = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end
      // Lanes never captured in this group go out as zero.
      if (xfer) snd_d[i] = flag_q[i] ? cap_q[i] : 8'h00;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      flag_q  <= '0;
      cap_q   <= '0;
      snd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      cap_q  <= cap_d;
      flag_q <= flag_d;
      ovf_q  <= ovf_d;
      snd_q  <= snd_d;
      case (state_q)
        IDLE: begin
          if (xfer) begin
            state_q <= SEND;
            cnt_q   <= 2'd0;
          end
        end
        SEND: begin
          if (out_ready) begin
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = (state_q == SEND);
  assign busy      = (state_q == SEND);
  assign out_last  = out_valid && (cnt_q == 2'd3);
  assign out_data  = snd_q[{cnt_q, 2'b00} +: 4];
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_ofm_collector.sv
// Directed bench for ofm_collector: full groups, split groups, flush, back-pressure, overflow, reset.
module tb_ofm_collector;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  ofm [16];
  logic [15:0] valid;
  logic        flush;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ofm_collector dut (
    .clk(clk), .reset_n(reset_n),
    .OFM_0(ofm[0]),   .OFM_1(ofm[1]),   .OFM_2(ofm[2]),   .OFM_3(ofm[3]),
    .OFM_4(ofm[4]),   .OFM_5(ofm[5]),   .OFM_6(ofm[6]),   .OFM_7(ofm[7]),
    .OFM_8(ofm[8]),   .OFM_9(ofm[9]),   .OFM_10(ofm[10]), .OFM_11(ofm[11]),
    .OFM_12(ofm[12]), .OFM_13(ofm[13]), .OFM_14(ofm[14]), .OFM_15(ofm[15]),
    .valid(valid), .flush(flush),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .overflow(overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_word(input string tag, input logic [31:0] w, input logic last);
    chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_data"}, out_data, w);
    chk({tag, "_last"}, {31'd0, out_last}, {31'd0, last});
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_vld"},  {31'd0, out_valid}, 32'd0);
    chk({tag, "_data"}, out_data, 32'd0);
    chk({tag, "_last"}, {31'd0, out_last}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_ovf"},  {31'd0, overflow}, 32'd0);
  endtask

  logic [31:0] exp_w0;

  initial begin
    reset_n   = 1'b0;
    valid     = 16'h0;
    flush     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) ofm[i] = 8'h00;
    #12;
    chk_idle_outputs("reset");
    reset_n = 1'b1;
    tick();

    // Full group in one cycle
    for (int i = 0; i < 16; i++) ofm[i] = 8'(i + 1);
    valid = 16'hFFFF;
    tick();
    valid = 16'h0;
    chk("t1_lat_vld", {31'd0, out_valid}, 32'd0);
    tick();
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk_word("t1_w0", 32'h04030201, 1'b0);
    tick();
    chk_word("t1_w1", 32'h08070605, 1'b0);
    tick();
    chk_word("t1_w2", 32'h0C0B0A09, 1'b0);
    tick();
    chk_word("t1_w3", 32'h100F0E0D, 1'b1);
    tick();
    chk("t1_end_vld", {31'd0, out_valid}, 32'd0);
    chk("t1_end_busy", {31'd0, busy}, 32'd0);

    // Group split across two cycles
    for (int i = 0; i < 16; i++) ofm[i] = 8'(8'h10 + i);
    valid = 16'hAAAA;
    tick();
    chk("t2_half_vld", {31'd0, out_valid}, 32'd0);
    valid = 16'h5555;
    tick();
    valid = 16'h0;
    chk("t2_lat_vld", {31'd0, out_valid}, 32'd0);
    tick();
    chk_word("t2_w0", 32'h13121110, 1'b0);
    tick();
    tick();
    tick();
    chk_word("t2_w3", 32'h1F1E1D1C, 1'b1);
    tick();
    chk("t2_end_vld", {31'd0, out_valid}, 32'd0);

    // Empty flush is ignored
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    chk("flush_empty_vld", {31'd0, out_valid}, 32'd0);

    // Partial group with flush
    for (int i = 0; i < 4; i++) ofm[i] = 8'(8'hA0 + i);
    valid = 16'h000F;
    tick();
    valid = 16'h0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
`ifdef OFM_COLLECTOR_RELU_EN
    exp_w0 = 32'h00000000;
`else
    exp_w0 = 32'hA3A2A1A0;
`endif
    chk_word("t3_w0", exp_w0, 1'b0);
    tick();
    chk_word("t3_w1", 32'h0, 1'b0);
    tick();
    chk_word("t3_w2", 32'h0, 1'b0);
    tick();
    chk_word("t3_w3", 32'h0, 1'b1);
    tick();
    chk("t3_end_vld", {31'd0, out_valid}, 32'd0);

    // Back-pressure during word 1
    for (int i = 0; i < 16; i++) ofm[i] = 8'(i + 1);
    valid = 16'hFFFF;
    tick();
    valid = 16'h0;
    tick();
    chk_word("t4_w0", 32'h04030201, 1'b0);
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_word("t4_hold", 32'h08070605, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    chk_word("t4_w2", 32'h0C0B0A09, 1'b0);
    tick();
    chk_word("t4_w3", 32'h100F0E0D, 1'b1);
    tick();
    chk("t4_end_vld", {31'd0, out_valid}, 32'd0);
    chk("t4_ovf", {31'd0, overflow}, 32'd0);

    // Lane overrun, then reset mid-SEND
    for (int i = 0; i < 16; i++) ofm[i] = 8'(8'h20 + i);
    ofm[2] = 8'h55;
    valid  = 16'h0004;
    tick();
    chk("t5_ovf_before", {31'd0, overflow}, 32'd0);
    ofm[2] = 8'h66;
    tick();
    chk("t5_ovf_set", {31'd0, overflow}, 32'd1);
    ofm[2] = 8'h77;
    valid  = 16'hFFFB;
    tick();
    valid = 16'h0;
    tick();
    chk_word("t5_w0", 32'h23552120, 1'b0);
    chk("t5_ovf_sticky", {31'd0, overflow}, 32'd1);
    out_ready = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    chk_idle_outputs("t5_rst");
    #3;
    reset_n   = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t5_post_rst_vld", {31'd0, out_valid}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
